// File: rtl/switch_debounce.sv
// Per-bit switch debouncer: 2-flop synchronizer, stability counter, rise/fall pulses.
// Define SWITCH_DEBOUNCE_IRQ_EN to add sticky edge_capture flags and a registered irq.
module switch_debounce #(
    parameter int                 WIDTH           = 1,
    parameter int                 DEBOUNCE_CYCLES = 50000,
    parameter int                 CNT_WIDTH       = 16,
    parameter logic [WIDTH-1:0]   RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    input  logic [WIDTH-1:0] irq_clear,
    output logic [WIDTH-1:0] edge_capture,
    output logic             irq
);

    localparam logic [CNT_WIDTH-1:0] CNT_TERM = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]     r_sync1;
    logic [WIDTH-1:0]     r_sync2;
    logic [WIDTH-1:0]     r_clean;
    logic [WIDTH-1:0]     r_rise;
    logic [WIDTH-1:0]     r_fall;
    logic [CNT_WIDTH-1:0] r_cnt [WIDTH];

    // Only r_sync2 feeds the counters; r_sync1 may be metastable.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= RESET_VALUE;
            r_sync2 <= RESET_VALUE;
            r_clean <= RESET_VALUE;
            r_rise  <= '0;
            r_fall  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= sw_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < WIDTH; i++) begin
                r_rise[i] <= 1'b0;
                r_fall[i] <= 1'b0;
                if (r_sync2[i] == r_clean[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_TERM) begin
                    r_clean[i] <= r_sync2[i];
                    r_cnt[i]   <= '0;
                    r_rise[i]  <= r_sync2[i];
                    r_fall[i]  <= ~r_sync2[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign sw_clean = r_clean;
    assign sw_rise  = r_rise;
    assign sw_fall  = r_fall;

`ifdef SWITCH_DEBOUNCE_IRQ_EN
    logic [WIDTH-1:0] r_edge;
    logic             r_irq;

    // A new edge in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_edge <= '0;
            r_irq  <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_rise[i] || r_fall[i]) begin
                    r_edge[i] <= 1'b1;
                end else if (irq_clear[i]) begin
                    r_edge[i] <= 1'b0;
                end
            end
            r_irq <= |r_edge;
        end
    end

    assign edge_capture = r_edge;
    assign irq          = r_irq;
`else
    logic w_unused_irq_clear;

    assign w_unused_irq_clear = ^irq_clear;
    assign edge_capture       = '0;
    assign irq                = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Directed self-checking bench for switch_debounce (WIDTH=2, DEBOUNCE_CYCLES=4).
// Expectations for edge_capture/irq follow SWITCH_DEBOUNCE_IRQ_EN.
module tb_switch_debounce;

`ifdef SWITCH_DEBOUNCE_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] sw_raw;
    logic [1:0] sw_clean;
    logic [1:0] sw_rise;
    logic [1:0] sw_fall;
    logic [1:0] irq_clear;
    logic [1:0] edge_capture;
    logic       irq;

    int nChecks = 0;
    int nFails  = 0;

    switch_debounce #(
        .WIDTH(2),
        .DEBOUNCE_CYCLES(4),
        .CNT_WIDTH(16),
        .RESET_VALUE(2'b00)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sw_raw(sw_raw),
        .sw_clean(sw_clean),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall),
        .irq_clear(irq_clear),
        .edge_capture(edge_capture),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive a level long enough to be accepted, then clear any captured edges.
    task automatic settle(input logic [1:0] v);
        sw_raw = v;
        step(8);
        irq_clear = 2'b11;
        step(1);
        irq_clear = 2'b00;
        step(2);
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        sw_raw    = 2'b11;
        irq_clear = 2'b00;
        step(3);
        nChecks++;
        if (sw_clean !== 2'b00) begin nFails++; $display("[TB] FAIL reset_clean: got %b expected %b", sw_clean, 2'b00); end
        nChecks++;
        if ({sw_rise, sw_fall} !== 4'b0000) begin nFails++; $display("[TB] FAIL reset_pulses: got %b expected %b", {sw_rise, sw_fall}, 4'b0000); end
        nChecks++;
        if ({edge_capture, irq} !== 3'b000) begin nFails++; $display("[TB] FAIL reset_irq: got %b expected %b", {edge_capture, irq}, 3'b000); end
        reset = 1'b0;
        step(5);
        nChecks++;
        if (sw_clean !== 2'b00) begin nFails++; $display("[TB] FAIL reset_release_early: got %b expected %b", sw_clean, 2'b00); end
        step(1);
        nChecks++;
        if (sw_clean !== 2'b11) begin nFails++; $display("[TB] FAIL reset_release_clean: got %b expected %b", sw_clean, 2'b11); end
        nChecks++;
        if (sw_rise !== 2'b11) begin nFails++; $display("[TB] FAIL reset_release_rise: got %b expected %b", sw_rise, 2'b11); end
        step(1);
        nChecks++;
        if (sw_rise !== 2'b00) begin nFails++; $display("[TB] FAIL reset_rise_width: got %b expected %b", sw_rise, 2'b00); end
    endtask

    task automatic test_rise();
        settle(2'b00);
        sw_raw = 2'b01;
        step(5);
        nChecks++;
        if ({sw_clean, sw_rise} !== 4'b0000) begin nFails++; $display("[TB] FAIL rise_early: got %b expected %b", {sw_clean, sw_rise}, 4'b0000); end
        step(1);
        nChecks++;
        if (sw_clean !== 2'b01) begin nFails++; $display("[TB] FAIL rise_clean: got %b expected %b", sw_clean, 2'b01); end
        nChecks++;
        if ({sw_rise, sw_fall} !== 4'b0100) begin nFails++; $display("[TB] FAIL rise_pulse: got %b expected %b", {sw_rise, sw_fall}, 4'b0100); end
        step(1);
        nChecks++;
        if ({sw_clean, sw_rise, sw_fall} !== 6'b010000) begin nFails++; $display("[TB] FAIL rise_after: got %b expected %b", {sw_clean, sw_rise, sw_fall}, 6'b010000); end
    endtask

    task automatic test_glitch();
        settle(2'b00);
        sw_raw = 2'b01;
        step(3);
        sw_raw = 2'b00;
        for (int k = 0; k < 8; k++) begin
            step(1);
            nChecks++;
            if ({sw_clean, sw_rise, sw_fall} !== 6'b000000) begin nFails++; $display("[TB] FAIL glitch_cycle%0d: got %b expected %b", k, {sw_clean, sw_rise, sw_fall}, 6'b000000); end
        end
        // A fresh step must still need the full count, proving the counter restarted.
        sw_raw = 2'b01;
        step(5);
        nChecks++;
        if (sw_clean !== 2'b00) begin nFails++; $display("[TB] FAIL glitch_recount_early: got %b expected %b", sw_clean, 2'b00); end
        step(1);
        nChecks++;
        if ({sw_clean, sw_rise} !== 4'b0101) begin nFails++; $display("[TB] FAIL glitch_recount: got %b expected %b", {sw_clean, sw_rise}, 4'b0101); end
    endtask

    task automatic test_bounce();
        settle(2'b00);
        for (int k = 0; k < 20; k++) begin
            sw_raw[0] = ~sw_raw[0];
            step(2);
            nChecks++;
            if ({sw_clean, sw_rise, sw_fall} !== 6'b000000) begin nFails++; $display("[TB] FAIL bounce_toggle%0d: got %b expected %b", k, {sw_clean, sw_rise, sw_fall}, 6'b000000); end
        end
        sw_raw = 2'b01;
        step(5);
        nChecks++;
        if ({sw_clean, sw_rise} !== 4'b0000) begin nFails++; $display("[TB] FAIL bounce_early: got %b expected %b", {sw_clean, sw_rise}, 4'b0000); end
        step(1);
        nChecks++;
        if ({sw_clean, sw_rise, sw_fall} !== 6'b010100) begin nFails++; $display("[TB] FAIL bounce_accept: got %b expected %b", {sw_clean, sw_rise, sw_fall}, 6'b010100); end
        step(1);
        nChecks++;
        if (sw_rise !== 2'b00) begin nFails++; $display("[TB] FAIL bounce_single_pulse: got %b expected %b", sw_rise, 2'b00); end
    endtask

    task automatic test_reset_midcount();
        settle(2'b00);
        sw_raw = 2'b01;
        step(4);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1);
            nChecks++;
            if ({sw_clean, sw_rise} !== 4'b0000) begin nFails++; $display("[TB] FAIL midcount_reset%0d: got %b expected %b", k, {sw_clean, sw_rise}, 4'b0000); end
        end
        reset = 1'b0;
        step(5);
        nChecks++;
        if ({sw_clean, sw_rise} !== 4'b0000) begin nFails++; $display("[TB] FAIL midcount_early: got %b expected %b", {sw_clean, sw_rise}, 4'b0000); end
        step(1);
        nChecks++;
        if ({sw_clean, sw_rise} !== 4'b0101) begin nFails++; $display("[TB] FAIL midcount_accept: got %b expected %b", {sw_clean, sw_rise}, 4'b0101); end
    endtask

    task automatic test_irq();
        logic [1:0] expEdge;
        logic       expIrq;
        settle(2'b10);
        sw_raw = 2'b00;
        step(6);
        nChecks++;
        if ({sw_clean, sw_fall, sw_rise} !== 6'b001000) begin nFails++; $display("[TB] FAIL irq_fall_pulse: got %b expected %b", {sw_clean, sw_fall, sw_rise}, 6'b001000); end
        nChecks++;
        if ({edge_capture, irq} !== 3'b000) begin nFails++; $display("[TB] FAIL irq_before_capture: got %b expected %b", {edge_capture, irq}, 3'b000); end
        step(1);
        expEdge = IRQ_EN ? 2'b10 : 2'b00;
        nChecks++;
        if ({edge_capture, irq} !== {expEdge, 1'b0}) begin nFails++; $display("[TB] FAIL irq_capture: got %b expected %b", {edge_capture, irq}, {expEdge, 1'b0}); end
        step(1);
        expIrq = IRQ_EN;
        nChecks++;
        if ({edge_capture, irq} !== {expEdge, expIrq}) begin nFails++; $display("[TB] FAIL irq_assert: got %b expected %b", {edge_capture, irq}, {expEdge, expIrq}); end
        // Clear coincides with a new bit-1 rise pulse: the flag must stay set.
        sw_raw = 2'b10;
        step(6);
        nChecks++;
        if (sw_rise !== 2'b10) begin nFails++; $display("[TB] FAIL irq_second_rise: got %b expected %b", sw_rise, 2'b10); end
        irq_clear = 2'b10;
        step(1);
        irq_clear = 2'b00;
        nChecks++;
        if ({edge_capture, irq} !== {expEdge, expIrq}) begin nFails++; $display("[TB] FAIL irq_set_wins: got %b expected %b", {edge_capture, irq}, {expEdge, expIrq}); end
        step(2);
        irq_clear = 2'b10;
        step(1);
        irq_clear = 2'b00;
        nChecks++;
        if ({edge_capture, irq} !== {2'b00, expIrq}) begin nFails++; $display("[TB] FAIL irq_clear_edge: got %b expected %b", {edge_capture, irq}, {2'b00, expIrq}); end
        step(1);
        nChecks++;
        if ({edge_capture, irq} !== 3'b000) begin nFails++; $display("[TB] FAIL irq_deassert: got %b expected %b", {edge_capture, irq}, 3'b000); end
    endtask

    initial begin
        reset     = 1'b1;
        sw_raw    = 2'b00;
        irq_clear = 2'b00;
        test_reset();
        test_rise();
        test_glitch();
        test_bounce();
        test_reset_midcount();
        test_irq();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
